// File: rtl/branching_flags_pkg.sv
// rtl/branching_flags_pkg.sv - flag bit map and widths shared by the branch flag unit
package branching_flags_pkg;

    localparam int COND_WIDTH     = 8;

    localparam int FLAG_ALWAYS    = 0;
    localparam int FLAG_ZERO      = 1;
    localparam int FLAG_NONZERO   = 2;
    localparam int FLAG_POSITIVE  = 3;
    localparam int FLAG_NEGATIVE  = 4;
    localparam int FLAG_CUSTOM    = 5;
    localparam int FLAG_UNCHANGED = 6;
    localparam int FLAG_EVEN      = 7;

    typedef logic [COND_WIDTH-1:0] flags_t;

endpackage

// File: rtl/branching_flags_threaded_if.sv
// rtl/branching_flags_threaded_if.sv - result, config and flag-read signals of the flag unit
interface branching_flags_threaded_if #(
    parameter int WORD_WIDTH        = 36,
    parameter int THREAD_ADDR_WIDTH = 3
);
    import branching_flags_pkg::*;

    logic [WORD_WIDTH-1:0]        R_prev;
    logic                         R_valid;
    logic [THREAD_ADDR_WIDTH-1:0] R_thread;
    logic [THREAD_ADDR_WIDTH-1:0] rd_thread;
    flags_t                       flags;
    logic                         flags_valid;
    logic                         cfg_we;
    logic [THREAD_ADDR_WIDTH-1:0] cfg_thread;
    logic [WORD_WIDTH-1:0]        cfg_mask;
    logic [WORD_WIDTH-1:0]        cfg_match;

    modport master (
        output R_prev, R_valid, R_thread, rd_thread,
        output cfg_we, cfg_thread, cfg_mask, cfg_match,
        input  flags, flags_valid
    );

    modport slave (
        input  R_prev, R_valid, R_thread, rd_thread,
        input  cfg_we, cfg_thread, cfg_mask, cfg_match,
        output flags, flags_valid
    );

endinterface

// File: rtl/branching_flags_eval.sv
// rtl/branching_flags_eval.sv - combinational flag vector for one result word
module branching_flags_eval
    import branching_flags_pkg::*;
#(
    parameter int WORD_WIDTH = 36
) (
    input  logic [WORD_WIDTH-1:0] r_i,
    input  logic [WORD_WIDTH-1:0] mask_i,
    input  logic [WORD_WIDTH-1:0] match_i,
    input  logic [WORD_WIDTH-1:0] last_r_i,
    input  logic                  last_valid_i,
    output flags_t                flags_o
);

    always_comb begin
        flags_o                 = '0;
        flags_o[FLAG_ALWAYS]    = 1'b1;
        flags_o[FLAG_ZERO]      = (r_i == '0);
        flags_o[FLAG_NONZERO]   = (r_i != '0);
        flags_o[FLAG_POSITIVE]  = ~r_i[WORD_WIDTH-1];
        flags_o[FLAG_NEGATIVE]  = r_i[WORD_WIDTH-1];
        // An all-zero mask would match everything; treat it as "not configured".
        flags_o[FLAG_CUSTOM]    = (mask_i != '0) && ((r_i & mask_i) == (match_i & mask_i));
        flags_o[FLAG_UNCHANGED] = last_valid_i && (r_i == last_r_i);
        flags_o[FLAG_EVEN]      = ~r_i[0];
    end

endmodule

// File: rtl/branching_flags_threaded.sv
// rtl/branching_flags_threaded.sv - per-thread branch flag table with stage-1 evaluation
// and a registered, write-first read port.
module branching_flags_threaded
    import branching_flags_pkg::*;
#(
    parameter int WORD_WIDTH        = 36,
    parameter int THREAD_COUNT      = 8,
    parameter int THREAD_ADDR_WIDTH = 3
) (
    input  logic                       clock,
    input  logic                       reset_n,
    branching_flags_threaded_if.slave  bus
);

    function automatic logic in_range(input logic [THREAD_ADDR_WIDTH-1:0] t);
        return int'(t) < THREAD_COUNT;
    endfunction

    logic                         s1_valid_q, s1_valid_d;
    logic [WORD_WIDTH-1:0]        s1_r_q, s1_r_d;
    logic [THREAD_ADDR_WIDTH-1:0] s1_thread_q, s1_thread_d;

    flags_t                       table_q  [THREAD_COUNT];
    logic [WORD_WIDTH-1:0]        last_r_q [THREAD_COUNT];
    logic [WORD_WIDTH-1:0]        mask_q   [THREAD_COUNT];
    logic [WORD_WIDTH-1:0]        match_q  [THREAD_COUNT];
    logic [THREAD_COUNT-1:0]      valid_q;

    flags_t                       flags_q, flags_d;
    logic                         flags_valid_q, flags_valid_d;
    flags_t                       eval_flags;

    branching_flags_eval #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_eval (
        .r_i          (s1_r_q),
        .mask_i       (mask_q[s1_thread_q]),
        .match_i      (match_q[s1_thread_q]),
        .last_r_i     (last_r_q[s1_thread_q]),
        .last_valid_i (valid_q[s1_thread_q]),
        .flags_o      (eval_flags)
    );

    always_comb begin
        s1_valid_d  = bus.R_valid && in_range(bus.R_thread);
        s1_r_d      = bus.R_prev;
        s1_thread_d = bus.R_thread;
    end

    // Read path: a same-edge table write to the read thread is forwarded.
    always_comb begin
        flags_d       = '0;
        flags_valid_d = 1'b0;
        if (in_range(bus.rd_thread)) begin
            if (s1_valid_q && (s1_thread_q == bus.rd_thread)) begin
                flags_d       = eval_flags;
                flags_valid_d = 1'b1;
            end else begin
                flags_d       = table_q[bus.rd_thread];
                flags_valid_d = valid_q[bus.rd_thread];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_q    <= 1'b0;
            s1_r_q        <= '0;
            s1_thread_q   <= '0;
            flags_q       <= '0;
            flags_valid_q <= 1'b0;
            valid_q       <= '0;
            for (int i = 0; i < THREAD_COUNT; i++) begin
                table_q[i]  <= '0;
                last_r_q[i] <= '0;
                mask_q[i]   <= '0;
                match_q[i]  <= '0;
            end
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_r_q        <= s1_r_d;
            s1_thread_q   <= s1_thread_d;
            flags_q       <= flags_d;
            flags_valid_q <= flags_valid_d;
            if (s1_valid_q) begin
                table_q[s1_thread_q]  <= eval_flags;
                last_r_q[s1_thread_q] <= s1_r_q;
                valid_q[s1_thread_q]  <= 1'b1;
            end
            // Evaluation this cycle already read the old mask/match above.
            if (bus.cfg_we && in_range(bus.cfg_thread)) begin
                mask_q[bus.cfg_thread]  <= bus.cfg_mask;
                match_q[bus.cfg_thread] <= bus.cfg_match;
            end
        end
    end

    assign bus.flags       = flags_q;
    assign bus.flags_valid = flags_valid_q;

endmodule
